// File: rtl/pio_pkg.sv
// Shared constants for the memory-mapped parallel I/O controller:
// register offsets within the 16-word window and the channel limit.
package pio_pkg;

  localparam logic [3:0] OFF_OUT  = 4'h0;
  localparam logic [3:0] OFF_SET  = 4'h4;
  localparam logic [3:0] OFF_IN   = 4'h8;
  localparam logic [3:0] OFF_EDGE = 4'hC;
  localparam logic [3:0] OFF_MASK = 4'hD;

  localparam int MAX_CH = 4;

endpackage

// File: rtl/pio_sync_edge.sv
// One input channel: two-flop synchroniser, a previous-value register and a
// combinational change flag comparing the synchronised word against it.
module pio_sync_edge #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              iRST_N,
  input  logic [DATA_W-1:0] async_in,
  output logic [DATA_W-1:0] sync_out,
  output logic              change
);

  logic [DATA_W-1:0] s1, s2, prev;

  // NOTE: flops use non-blocking assignments so s1->s2->prev shift as a true
  // pipeline; blocking here would collapse the chain into a single stage.
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync_out = s2;
  // prev resets to 0, so a nonzero input at reset release counts as a change.
  assign change   = (s2 != prev);

endmodule

// File: rtl/parallel_io_ctrl.sv
// Memory-mapped parallel I/O controller: decodes a 16-word window, holds the
// output/edge/mask registers and muxes load data between RAM and I/O.
module parallel_io_ctrl
  import pio_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 16,
  parameter int                N_OUT   = 2,
  parameter int                N_IN    = 2,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'('hFFF0)
) (
  input  logic                     clk,
  input  logic                     iRST_N,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     we,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        rdata,
  output logic [N_OUT*DATA_W-1:0]  out_port,
  input  logic [N_IN*DATA_W-1:0]   in_port,
  output logic                     irq
);

  if (N_OUT < 1 || N_OUT > MAX_CH) begin : g_bad_n_out
    $error("parallel_io_ctrl: N_OUT must be 1..4");
  end
  if (N_IN < 1 || N_IN > MAX_CH) begin : g_bad_n_in
    $error("parallel_io_ctrl: N_IN must be 1..4");
  end

  logic              io_hit, io_wr;
  logic [3:0]        off;
  logic [DATA_W-1:0] out_q   [N_OUT];
  logic [DATA_W-1:0] in_sync [N_IN];
  logic [N_IN-1:0]   change, edge_q, mask_q, w1c;
  logic [DATA_W-1:0] io_rdata;

  assign io_hit = (addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
  assign off    = addr[3:0];
  assign io_wr  = we & io_hit;
  assign mem_we = we & ~io_hit;

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    pio_sync_edge #(.DATA_W(DATA_W)) u_sync (
      .clk      (clk),
      .iRST_N   (iRST_N),
      .async_in (in_port[g*DATA_W +: DATA_W]),
      .sync_out (in_sync[g]),
      .change   (change[g])
    );
  end

  // NOTE: the output register array is tiny and drives pins, so every entry
  // is reset; large storage arrays would normally be left unreset.
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
    end else if (io_wr) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (off == OFF_OUT + 4'(k))      out_q[k] <= wdata;
        else if (off == OFF_SET + 4'(k)) out_q[k] <= out_q[k] | wdata;
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_port[g*DATA_W +: DATA_W] = out_q[g];
  end

  assign w1c = (io_wr && off == OFF_EDGE) ? wdata[N_IN-1:0] : '0;

  // Clear is applied before set so a change in the W1C cycle keeps the bit.
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      edge_q <= '0;
      mask_q <= '0;
    end else begin
      edge_q <= (edge_q & ~w1c) | change;
      if (io_wr && off == OFF_MASK) mask_q <= wdata[N_IN-1:0];
    end
  end

  assign irq = |(edge_q & mask_q);

  // NOTE: io_rdata gets a default before any conditional assignment so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    io_rdata = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (off == OFF_OUT + 4'(k) || off == OFF_SET + 4'(k)) io_rdata = out_q[k];
    end
    for (int k = 0; k < N_IN; k++) begin
      if (off == OFF_IN + 4'(k)) io_rdata = in_sync[k];
    end
    if (off == OFF_EDGE) io_rdata[N_IN-1:0] = edge_q;
    if (off == OFF_MASK) io_rdata[N_IN-1:0] = mask_q;
  end

  assign rdata = io_hit ? io_rdata : mem_rdata;

endmodule

// File: tb/tb_parallel_io_ctrl.sv
// Self-checking bench for parallel_io_ctrl: bus vector table with an out_port
// scoreboard, then hand sequences for input sync, edge/W1C/irq and reset.
module tb_parallel_io_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int N_OUT  = 2;
  localparam int N_IN   = 2;

  logic                    clk = 1'b0;
  logic                    iRST_N;
  logic [ADDR_W-1:0]       addr;
  logic                    we;
  logic [DATA_W-1:0]       wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    mem_we;
  logic [DATA_W-1:0]       rdata;
  logic [N_OUT*DATA_W-1:0] out_port;
  logic [N_IN*DATA_W-1:0]  in_port;
  logic                    irq;

  parallel_io_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_OUT(N_OUT), .N_IN(N_IN),
    .IO_BASE(16'hFFF0)
  ) dut (
    .clk(clk), .iRST_N(iRST_N), .addr(addr), .we(we), .wdata(wdata),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .rdata(rdata),
    .out_port(out_port), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] mrd;
    logic [15:0] exp_rdata;
    logic        exp_mem_we;
    logic [31:0] exp_out;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_q[$];

  // Writes at the next edge; leaves the bench at posedge+1 with we low.
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; we = 1'b1; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    addr = a; #1;
    d = rdata;
  endtask

  logic [15:0] r;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "timeout");
  end

  initial begin
    iRST_N = 1'b0; addr = 16'h0040; we = 1'b0; wdata = '0;
    mem_rdata = 16'h1234; in_port = '0;

    vecs.push_back('{16'h0040, 1'b0, 16'h0000, 16'h1234, 16'h1234, 1'b0, 32'h0000_0000});
    vecs.push_back('{16'hFFF0, 1'b1, 16'h00A5, 16'h0000, 16'h0000, 1'b0, 32'h0000_00A5});
    vecs.push_back('{16'hFFF4, 1'b1, 16'h0F00, 16'h0000, 16'h00A5, 1'b0, 32'h0000_0FA5});
    vecs.push_back('{16'h0010, 1'b1, 16'hBEEF, 16'h5555, 16'h5555, 1'b1, 32'h0000_0FA5});
    vecs.push_back('{16'hFFFE, 1'b1, 16'h1111, 16'h9999, 16'h0000, 1'b0, 32'h0000_0FA5});
    vecs.push_back('{16'hFFFE, 1'b0, 16'h0000, 16'h9999, 16'h0000, 1'b0, 32'h0000_0FA5});
    vecs.push_back('{16'hFFF0, 1'b0, 16'h0000, 16'hABCD, 16'h0FA5, 1'b0, 32'h0000_0FA5});
    vecs.push_back('{16'hFFF1, 1'b1, 16'hC3C3, 16'h0000, 16'h0000, 1'b0, 32'hC3C3_0FA5});
    vecs.push_back('{16'hFFF5, 1'b1, 16'h0004, 16'h0000, 16'hC3C3, 1'b0, 32'hC3C7_0FA5});
    vecs.push_back('{16'hFFF1, 1'b0, 16'h0000, 16'h0000, 16'hC3C7, 1'b0, 32'hC3C7_0FA5});
    vecs.push_back('{16'hFFF8, 1'b1, 16'h7777, 16'h0000, 16'h0000, 1'b0, 32'hC3C7_0FA5});
    vecs.push_back('{16'hFFF9, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 32'hC3C7_0FA5});
    vecs.push_back('{16'hFFFD, 1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 32'hC3C7_0FA5});
    vecs.push_back('{16'hFFFD, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 32'hC3C7_0FA5});
    vecs.push_back('{16'hFFFD, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 32'hC3C7_0FA5});
    vecs.push_back('{16'hFFFC, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 32'hC3C7_0FA5});
    vecs.push_back('{16'hFFF2, 1'b1, 16'h5A5A, 16'h7070, 16'h0000, 1'b0, 32'hC3C7_0FA5});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out_port", out_port, 32'h0);
    check("reset irq", {31'b0, irq}, 32'h0);
    check("reset mem_we", {31'b0, mem_we}, 32'h0);
    check("reset rdata passthrough", {16'h0, rdata}, 32'h1234);
    @(negedge clk); iRST_N = 1'b1;
    @(posedge clk); #1;

    // Table: combinational outputs checked before the edge, out_port after
    foreach (vecs[i]) begin
      addr = vecs[i].addr; we = vecs[i].we; wdata = vecs[i].wdata;
      mem_rdata = vecs[i].mrd;
      #1;
      check($sformatf("vec%0d rdata", i), {16'h0, rdata}, {16'h0, vecs[i].exp_rdata});
      check($sformatf("vec%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].exp_mem_we});
      sb_q.push_back(vecs[i].exp_out);
      @(posedge clk); #1;
      we = 1'b0;
      check($sformatf("vec%0d out_port", i), out_port, sb_q.pop_front());
    end

    // Input sync latency and edge capture on ch1
    in_port = {16'h0003, 16'h0000};
    rd(16'hFFF9, r); check("in1 before t", {16'h0, r}, 32'h0);
    @(posedge clk); #1;
    rd(16'hFFF9, r); check("in1 after t", {16'h0, r}, 32'h0);
    @(posedge clk); #1;
    rd(16'hFFF9, r); check("in1 after t+1", {16'h0, r}, 32'h0003);
    rd(16'hFFFC, r); check("edge after t+1", {16'h0, r}, 32'h0);
    @(posedge clk); #1;
    rd(16'hFFFC, r); check("edge after t+2", {16'h0, r}, 32'h0002);
    check("irq masked off", {31'b0, irq}, 32'h0);

    // Mask enables irq; W1C clears it
    wr(16'hFFFD, 16'h0002);
    check("irq after mask", {31'b0, irq}, 32'h1);
    wr(16'hFFFC, 16'h0002);
    check("irq after w1c", {31'b0, irq}, 32'h0);
    rd(16'hFFFC, r); check("edge after w1c", {16'h0, r}, 32'h0);

    // Change lands in the same cycle as the W1C: set wins
    in_port = {16'h0007, 16'h0000};
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr(16'hFFFC, 16'h0002);
    rd(16'hFFFC, r); check("edge set beats w1c", {16'h0, r}, 32'h0002);
    check("irq set beats w1c", {31'b0, irq}, 32'h1);
    wr(16'hFFFC, 16'h0002);
    rd(16'hFFFC, r); check("edge cleared again", {16'h0, r}, 32'h0);

    // Build OUT_0=FFFF, EDGE=11, irq=1, then reset asynchronously mid-cycle
    wr(16'hFFF0, 16'hFFFF);
    in_port = {16'h0000, 16'h0001};
    repeat (3) @(posedge clk);
    #1;
    rd(16'hFFFC, r); check("edge both set", {16'h0, r}, 32'h0003);
    wr(16'hFFFD, 16'h0003);
    check("irq before reset", {31'b0, irq}, 32'h1);
    check("out0 before reset", {16'h0, out_port[15:0]}, 32'hFFFF);
    #2;
    iRST_N = 1'b0;
    #1;
    check("async reset out_port", out_port, 32'h0);
    check("async reset irq", {31'b0, irq}, 32'h0);
    rd(16'hFFFC, r); check("async reset edge", {16'h0, r}, 32'h0);
    mem_rdata = 16'h1234;
    rd(16'h0040, r); check("reset ram read", {16'h0, r}, 32'h1234);

    // Nonzero input at release registers as a change two edges later
    @(negedge clk); iRST_N = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd(16'hFFFC, r); check("edge 2 after release", {16'h0, r}, 32'h0);
    rd(16'hFFF8, r); check("in0 after release", {16'h0, r}, 32'h0001);
    @(posedge clk); #1;
    rd(16'hFFFC, r); check("edge 3 after release", {16'h0, r}, 32'h0001);
    check("irq mask reset", {31'b0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
